// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter
interface alu_arbiter_if #(parameter int N = 8);
    logic [3:0] req;
    logic [4*N-1:0] a_bus;
    logic [4*N-1:0] b_bus;
    logic [11:0] mode_bus;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [N-1:0] rsp_result;
    logic busy;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0] alu_mode;
    logic [N-1:0] alu_y;
    logic [15:0] op_count;
    modport master (
        output req, a_bus, b_bus, mode_bus, alu_y,
        input gnt, done, rsp_result, busy, alu_a, alu_b, alu_mode, op_count
    );
    modport slave (
        input req, a_bus, b_bus, mode_bus, alu_y,
        output gnt, done, rsp_result, busy, alu_a, alu_b, alu_mode, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU by four requesters; ALU_ARB_OPCOUNT_EN enables op_count
module alu_arbiter #(parameter int N = 8) (
    input logic clk,
    input logic reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    state_t state_n;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [1:0] win;
    logic arb;
    always_comb begin
        win = ptr;
        for (int i = 3; i >= 0; i--)
            if (bus.req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
    assign arb = state == IDLE && |bus.req;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (arb ? EXEC : IDLE) : state == EXEC ? RESP : IDLE;
    end
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            sel <= '0;
            bus.gnt <= '0;
            bus.done <= '0;
            bus.busy <= 1'b0;
            bus.rsp_result <= '0;
            bus.alu_a <= '0;
            bus.alu_b <= '0;
            bus.alu_mode <= '0;
        end else begin
            bus.gnt <= arb ? 4'b1 << win : 4'b0;
            bus.done <= state == EXEC ? 4'b1 << sel : 4'b0;
            bus.busy <= state_n != IDLE;
            if (arb) begin
                sel <= win;
                ptr <= win + 2'd1;
                bus.alu_a <= bus.a_bus[win*N +: N];
                bus.alu_b <= bus.b_bus[win*N +: N];
                bus.alu_mode <= bus.mode_bus[win*3 +: 3];
            end
            if (state == EXEC) bus.rsp_result <= bus.alu_y;
        end
    end
`ifdef ALU_ARB_OPCOUNT_EN
    logic [15:0] op_cnt;
    always_ff @(posedge clk)
        if (reset) op_cnt <= '0;
        else if (state == RESP && op_cnt != 16'hFFFF) op_cnt <= op_cnt + 16'd1;
    assign bus.op_count = op_cnt;
`else
    assign bus.op_count = 16'h0000;
`endif
endmodule
